// File: rtl/sample_stim_pkg.sv
// rtl/sample_stim_pkg.sv - shared types and constants for the sample stimulus generator
package sample_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int P_OF(input int w);
        return 3 * w;
    endfunction

    // Fibonacci feedback taps for x^9 + x^5 + 1: bits 8 and 4 of a left-shifting register
    localparam logic [8:0] LFSR_TAPS_9 = 9'h110;

endpackage

// File: rtl/sample_stim_src.sv
// rtl/sample_stim_src.sv - pattern source: binary counter, or LFSR when SAMPLE_STIM_LFSR_EN is defined
module sample_stim_src
    import sample_stim_pkg::*;
#(
    parameter int           P    = 9,
    parameter logic [P-1:0] SEED = {{(P-1){1'b0}}, 1'b1}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         advance,
    output logic [P-1:0] pattern,
    output logic         last
);

`ifdef SAMPLE_STIM_LFSR_EN
    localparam logic [P-1:0] TAPS = P'(LFSR_TAPS_9);

    logic [P-1:0] lfsr_next;

    assign lfsr_next = {pattern[P-2:0], ^(pattern & TAPS)};
    // The all-zero pattern is emitted once up front; the LFSR never revisits it
    assign last      = (pattern != '0) && (lfsr_next == SEED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= '0;
        end else if (load) begin
            pattern <= '0;
        end else if (advance) begin
            pattern <= (pattern == '0) ? SEED : lfsr_next;
        end
    end
`else
    logic seed_unused;

    assign seed_unused = ^SEED;
    assign last        = &pattern;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= '0;
        end else if (load) begin
            pattern <= '0;
        end else if (advance) begin
            pattern <= pattern + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/sample_stim_gen.sv
// rtl/sample_stim_gen.sv - exhaustive a/b/c stimulus over valid/ready; SAMPLE_STIM_LFSR_EN selects LFSR order
module sample_stim_gen
    import sample_stim_pkg::*;
#(
    parameter int                   W    = 3,
    parameter logic [P_OF(W)-1:0]   SEED = {{(P_OF(W)-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     a_o,
    output logic [W-1:0]     b_o,
    output logic [W-1:0]     c_o,
    output logic             vld_o,
    input  logic             rdy_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [P_OF(W):0] cnt_o
);

    localparam int P = P_OF(W);

    state_t       state;
    state_t       state_nxt;
    logic [P-1:0] pattern;
    logic         last;
    logic         xfer;
    logic         load;

    assign xfer = (state == RUN) && rdy_i;
    assign load = (state == IDLE) && start && !abort;

    // The source stops on the final pattern so the outputs keep showing it after the run
    sample_stim_src #(
        .P    (P),
        .SEED (SEED)
    ) u_src (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (xfer && !last),
        .pattern (pattern),
        .last    (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vld_o     = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                vld_o  = 1'b1;
                busy_o = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_o <= '0;
        end else if (load) begin
            cnt_o <= '0;
        end else if (xfer) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

    assign a_o = pattern[P-1:2*W];
    assign b_o = pattern[2*W-1:W];
    assign c_o = pattern[W-1:0];

endmodule

// File: tb/tb_sample_stim_gen.sv
// tb/tb_sample_stim_gen.sv - scoreboard bench for sample_stim_gen (counter or SAMPLE_STIM_LFSR_EN order)
module tb_sample_stim_gen;

    localparam int           W    = 3;
    localparam int           P    = 3 * W;
    localparam int           NPAT = 1 << P;
    localparam logic [P-1:0] SEED = 9'h001;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         rdy_i = 1'b0;
    logic [W-1:0] a_o;
    logic [W-1:0] b_o;
    logic [W-1:0] c_o;
    logic         vld_o;
    logic         busy_o;
    logic         done_o;
    logic [P:0]   cnt_o;

    int           rdy_mode = 1;
    int           total    = 0;
    int           bad      = 0;
    logic [P-1:0] exp_q[$];
    logic [P-1:0] exp_last;
    bit           seen[NPAT];
    int           xfer_cnt = 0;
    logic         prev_hold = 1'b0;
    logic [P:0]   prev_out;
    logic [P-1:0] mon_pat;
    logic [P-1:0] exp_pat;

    sample_stim_gen #(
        .W    (W),
        .SEED (SEED)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .a_o    (a_o),
        .b_o    (b_o),
        .c_o    (c_o),
        .vld_o  (vld_o),
        .rdy_i  (rdy_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .cnt_o  (cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) rdy_i = ($urandom_range(0, 1) != 0);
        else               rdy_i = (rdy_mode == 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Expected order for one full run
    task automatic push_run();
        logic [P-1:0] s;
        exp_q.delete();
`ifdef SAMPLE_STIM_LFSR_EN
        exp_q.push_back('0);
        s = SEED;
        for (int i = 1; i < NPAT; i++) begin
            exp_q.push_back(s);
            exp_last = s;
            s = {s[P-2:0], s[8] ^ s[4]};
        end
`else
        for (int i = 0; i < NPAT; i++) exp_q.push_back(P'(i));
        exp_last = 9'h1FF;
`endif
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (start && !abort && !busy_o && !done_o) begin
                xfer_cnt = 0;
                foreach (seen[i]) seen[i] = 1'b0;
            end
            if (prev_hold) check("hold_stable", {vld_o, a_o, b_o, c_o}, prev_out);
            prev_hold = vld_o && !rdy_i;
            prev_out  = {vld_o, a_o, b_o, c_o};
            if (vld_o && rdy_i) begin
                mon_pat = {a_o, b_o, c_o};
                check("cnt_before_xfer", cnt_o, xfer_cnt);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer: got pattern 0x%0h with empty queue, want none", mon_pat);
                end else begin
                    exp_pat = exp_q.pop_front();
                    check("pattern", mon_pat, exp_pat);
                end
                check("unique", seen[mon_pat], 0);
                seen[mon_pat] = 1'b1;
                xfer_cnt++;
            end
        end
    end

    task automatic run(input int inj, input int bound, output int done_at);
        int ndone;
        ndone   = 0;
        done_at = -1;
        push_run();
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            #1;
            if (k >= 1) start = (inj > 0 && xfer_cnt == inj);
            if (done_o) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = k;
                    check("cnt_at_done", cnt_o, NPAT);
                    check("xfers_at_done", xfer_cnt, NPAT);
                end
            end
            if (done_at >= 0 && k >= done_at + 3) break;
        end
        start = 1'b0;
        check("done_pulses", ndone, 1);
        check("final_pattern", {a_o, b_o, c_o}, exp_last);
        check("vld_after_run", vld_o, 0);
        check("busy_after_run", busy_o, 0);
        check("cnt_held", cnt_o, NPAT);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int d;
        int nd;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pattern", {a_o, b_o, c_o}, 0);
        check("rst_flags", {vld_o, busy_o, done_o}, 0);
        check("rst_cnt", cnt_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_flags", {vld_o, busy_o, done_o}, 0);

        // full run, no backpressure
        rdy_mode = 1;
        run(0, 700, d);
        check("done_latency", d, 513);

        // random backpressure
        rdy_mode = 2;
        run(0, 4000, d);
        rdy_mode = 1;

        // abort after 100 transfers, then replay
        push_run();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 400 && xfer_cnt < 100; k++) begin
            @(negedge clk);
            #1;
        end
        check("abort_reach", xfer_cnt, 100);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_vld", vld_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_cnt", cnt_o, 100);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_o) nd++;
        end
        check("abort_no_done", nd, 0);
        check("abort_cnt_frozen", cnt_o, 100);
        exp_q.delete();
        run(0, 700, d);
        check("replay_latency", d, 513);

        // start during RUN is ignored
        run(50, 700, d);
        check("inject_latency", d, 513);

        // start and abort together in IDLE
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy_o, 0);
        check("start_abort_vld", vld_o, 0);
        check("start_abort_cnt", cnt_o, NPAT);

        // asynchronous reset mid-run
        push_run();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 200 && xfer_cnt < 30; k++) @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pattern", {a_o, b_o, c_o}, 0);
        check("async_rst_flags", {vld_o, busy_o, done_o}, 0);
        check("async_rst_cnt", cnt_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("post_rst_idle", {vld_o, busy_o, done_o}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_stim_gen.md
Name: sample_stim_gen

Overview:
- Upstream stimulus stage for the gate-level sample circuits.
- Produces every combination of the a/b/c input vectors, exhaustively and exactly once per run, and presents them over a valid/ready handshake.
- Downstream is the netlist under test plus its response capture. The capture raises ready when it has sampled y for the current pattern.
- Run control is a start/abort/done FSM driven by the test controller.

Parameters:
- W, 3, width of each of a, b, c; pattern width P = 3*W.
- SEED, 9'h1, LFSR seed; P bits, nonzero; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a run when idle.
- abort  in  1  terminates a run in progress.
- a_o  out  W  stimulus a = pattern[P-1:2W].
- b_o  out  W  stimulus b = pattern[2W-1:W].
- c_o  out  W  stimulus c = pattern[W-1:0].
- vld_o  out  1  a_o/b_o/c_o hold a valid pattern.
- rdy_i  in  1  consumer accepted the current pattern.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse after the last pattern is accepted.
- cnt_o  out  P+1  number of patterns accepted in the current or last run.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - a_o/b_o/c_o = 0; vld_o, busy_o, done_o = 0; cnt_o = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1 and abort=0.
  - Pattern loads 0 and cnt_o clears to 0 on that edge.
  - vld_o=1 and busy_o=1 from the next cycle (latency 1).
- In RUN, a transfer occurs on any cycle with vld_o & rdy_i:
  - cnt_o increments on that edge.
  - The pattern advances; the next pattern is valid the following cycle with no bubble.
  - Throughput is 1 pattern/cycle when rdy_i is held high.
- With vld_o=1 and rdy_i=0, a_o/b_o/c_o/vld_o hold stable.
- Counter mode: pattern = 0, 1, ..., 2^P-1 (512 patterns for W=3).
- Last pattern (2^P-1) accepted:
  - Next state is DONE; vld_o=0, busy_o=0, cnt_o = 2^P.
- DONE lasts one cycle with done_o=1, then goes to IDLE.
- Outputs hold the last pattern after the run; cnt_o holds until the next start.
- start while in RUN or DONE is ignored.
- abort=1 in RUN:
  - Next cycle: IDLE, vld_o=0, busy_o=0, no done_o pulse; cnt_o freezes.
  - A transfer in the abort cycle still counts.
- start and abort both high in IDLE: abort wins, stays IDLE.
- rst asserted mid-run: immediate return to reset values; no done_o.
- cnt_o is P+1 bits so that 2^P is representable with no wrap.

Optional Feature:
- Macro: SAMPLE_STIM_LFSR_EN.
- Defined:
  - Pattern order is 0 first, then a maximal-length Fibonacci LFSR (x^9+x^5+1 for P=9) seeded with SEED, running 2^P-1 steps.
  - Total is still 2^P patterns, each exactly once.
  - The last pattern is the state preceding SEED.
  - The LFSR reloads SEED on start.
- Undefined: binary counter order as above; SEED ignored; no LFSR logic is synthesised.

Decomposition:
- Shared package sample_stim_pkg:
  - state enum (IDLE/RUN/DONE);
  - function P_OF(W);
  - LFSR tap constant for P=9.
- Sub-module sample_stim_src: pattern source.
  - Inputs: load, advance.
  - Outputs: pattern, last flag.
  - Holds the counter or the LFSR under the macro.
- The top holds the FSM, the handshake and cnt_o.

Test Plan:
- Reset then start, rdy_i=1 constant:
  - a/b/c = 0,0,0 first; cnt_o steps 0..512.
  - done_o pulses exactly once, 513 cycles after start.
  - Final a_o=b_o=c_o=7.
- rdy_i random 50% backpressure:
  - Outputs never change while vld_o & !rdy_i.
  - 512 unique patterns; cnt_o=512 at done.
- abort asserted after 100 transfers:
  - vld_o=0 next cycle, cnt_o=100, no done_o.
  - A fresh start replays from pattern 0.
- start during RUN at transfer 50: no restart; the run completes with cnt_o=512. Also start+abort together in IDLE: stays IDLE.
- rst pulsed mid-run, asynchronously between edges: outputs zero immediately; state IDLE after release.
- With SAMPLE_STIM_LFSR_EN, SEED=1:
  - First pattern 0, second 9'h001.
  - All 512 values are seen exactly once; done_o at cnt_o=512.
